// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types and helpers for the forwarding/hazard controller
package fwd_pkg;

  localparam int FWD_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                      valid;
    logic [FWD_REG_ADDR_W-1:0] rs1;
    logic [FWD_REG_ADDR_W-1:0] rs2;
    logic [FWD_REG_ADDR_W-1:0] rd;
    logic                      wren;
    logic                      load;
  } ex_stage_t;

  typedef struct packed {
    logic                      valid;
    logic [FWD_REG_ADDR_W-1:0] rd;
    logic                      wren;
    logic                      load;
  } mem_stage_t;

  typedef struct packed {
    logic                      valid;
    logic [FWD_REG_ADDR_W-1:0] rd;
    logic                      wren;
  } wb_stage_t;

  // A stage produces a usable result only if it is live, writes, and targets a non-x0 register
  function automatic logic is_writer(input logic valid, input logic wren,
                                     input logic [FWD_REG_ADDR_W-1:0] rd);
    return valid && wren && (rd != '0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - picks the forwarding source for one EX operand
module fwd_match
  import fwd_pkg::*;
(
  input  logic [FWD_REG_ADDR_W-1:0] i_src,
  input  mem_stage_t                i_mem,
  input  wb_stage_t                 i_wb,
  output fwd_sel_e                  o_sel
);

  // Youngest writer wins; a load in MEM has no data yet so it defers to the WB check
  always_comb begin
    o_sel = FWD_REG;
    if (is_writer(i_mem.valid, i_mem.wren, i_mem.rd) && !i_mem.load && (i_mem.rd == i_src)) begin
      o_sel = FWD_MEM;
    end else if (is_writer(i_wb.valid, i_wb.wren, i_wb.rd) && (i_wb.rd == i_src)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// rtl/fwd_ctrl.sv - forwarding select and load-use stall control for the 5-stage core
module fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = FWD_REG_ADDR_W,
  parameter int SEL_W      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_rd_wren,
  input  logic                  i_id_is_load,
  input  logic                  i_stall,
  input  logic                  i_flush,
  output logic [SEL_W-1:0]      o_fwd_a_sel,
  output logic [SEL_W-1:0]      o_fwd_b_sel,
  output logic                  o_load_use_stall
);

  ex_stage_t  ex_q,  ex_d;
  mem_stage_t mem_q, mem_d;
  wb_stage_t  wb_q,  wb_d;

  fwd_sel_e sel_a;
  fwd_sel_e sel_b;
  logic     load_use;

  fwd_match u_match_a (
    .i_src (ex_q.rs1),
    .i_mem (mem_q),
    .i_wb  (wb_q),
    .o_sel (sel_a)
  );

  fwd_match u_match_b (
    .i_src (ex_q.rs2),
    .i_mem (mem_q),
    .i_wb  (wb_q),
    .o_sel (sel_b)
  );

  // A bubble in EX has no operands to forward, so it always reads the register file
  assign o_fwd_a_sel = SEL_W'(ex_q.valid ? sel_a : FWD_REG);
  assign o_fwd_b_sel = SEL_W'(ex_q.valid ? sel_b : FWD_REG);

  // Rs2 is compared even for instructions that ignore it; the occasional extra bubble is cheap
  assign load_use = i_id_valid && ex_q.load && is_writer(ex_q.valid, ex_q.wren, ex_q.rd) &&
                    ((ex_q.rd == i_id_rs1) || (ex_q.rd == i_id_rs2));
  assign o_load_use_stall = load_use;

  // Shadow pipeline advance: freeze beats flush, flush beats load-use bubble
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!i_stall) begin
      wb_d.valid  = mem_q.valid;
      wb_d.rd     = mem_q.rd;
      wb_d.wren   = mem_q.wren;
      mem_d.valid = ex_q.valid;
      mem_d.rd    = ex_q.rd;
      mem_d.wren  = ex_q.wren;
      mem_d.load  = ex_q.load;
      if (i_flush || load_use) begin
        ex_d = '0;
      end else begin
        ex_d.valid = i_id_valid;
        ex_d.rs1   = i_id_rs1;
        ex_d.rs2   = i_id_rs2;
        ex_d.rd    = i_id_rd;
        ex_d.wren  = i_id_rd_wren;
        ex_d.load  = i_id_is_load;
      end
    end
  end

  // Stage registers; reset drops every in-flight entry at once
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb/tb_fwd_ctrl.sv - directed vector bench for fwd_ctrl
module tb_fwd_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_wren;
  logic       id_load;
  logic       stall;
  logic       flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       lu_stall;

  int checks;
  int failures;

  fwd_ctrl dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_id_valid       (id_valid),
    .i_id_rs1         (id_rs1),
    .i_id_rs2         (id_rs2),
    .i_id_rd          (id_rd),
    .i_id_rd_wren     (id_wren),
    .i_id_is_load     (id_load),
    .i_stall          (stall),
    .i_flush          (flush),
    .o_fwd_a_sel      (fwd_a),
    .o_fwd_b_sel      (fwd_b),
    .o_load_use_stall (lu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wren;
    logic       load;
    logic       stl;
    logic       fls;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       es;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic vld, input int rs1, input int rs2, input int rd,
                              input logic wren, input logic load, input logic stl,
                              input logic fls, input int ea, input int eb, input logic es);
    vec_t v;
    v.vld  = vld;
    v.rs1  = 5'(rs1);
    v.rs2  = 5'(rs2);
    v.rd   = 5'(rd);
    v.wren = wren;
    v.load = load;
    v.stl  = stl;
    v.fls  = fls;
    v.ea   = 2'(ea);
    v.eb   = 2'(eb);
    v.es   = es;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input int rs1, input int rs2, input int rd,
                       input logic wren, input logic load, input logic stl, input logic fls);
    id_valid = vld;
    id_rs1   = 5'(rs1);
    id_rs2   = 5'(rs2);
    id_rd    = 5'(rd);
    id_wren  = wren;
    id_load  = load;
    stall    = stl;
    flush    = fls;
  endtask

  task automatic chk_out(input string tag, input int ea, input int eb, input int es);
    chk({tag, "_a"},     int'(fwd_a),    ea);
    chk({tag, "_b"},     int'(fwd_b),    eb);
    chk({tag, "_stall"}, int'(lu_stall), es);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // ALU chain: add x5,x1,x2 ; sub x6,x5,x7
    tbl.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0));   // c0
    tbl.push_back(mk(1, 5, 7, 6, 1, 0, 0, 0, 0, 0, 0));   // c1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));   // c2 sub in EX
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // c3
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // c4
    // Gap of one: add x5 ; nop ; or x8,x1,x5
    tbl.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0));   // c5
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // c6
    tbl.push_back(mk(1, 1, 5, 8, 1, 0, 0, 0, 0, 0, 0));   // c7
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));   // c8 or in EX
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // c9
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // c10
    // Load-use: lw x9,(x3) ; add x10,x9,x9
    tbl.push_back(mk(1, 3, 0, 9, 1, 1, 0, 0, 0, 0, 0));   // c11
    tbl.push_back(mk(1, 9, 9, 10, 1, 0, 0, 0, 0, 0, 1));  // c12 stall
    tbl.push_back(mk(1, 9, 9, 10, 1, 0, 0, 0, 0, 0, 0));  // c13 bubble in EX
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0));   // c14 add in EX
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // c15
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // c16
    // x0 writes never forward
    tbl.push_back(mk(1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0));   // c17 add x0
    tbl.push_back(mk(1, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0));  // c18 add x11,x0,x0
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // c19
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // c20
    tbl.push_back(mk(1, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0));   // c21 lw x0
    tbl.push_back(mk(1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0));  // c22 no stall on x0
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // c23
    // Youngest writer: addi x4 ; addi x4 ; add x13,x4,x4
    tbl.push_back(mk(1, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0));   // c24
    tbl.push_back(mk(1, 2, 0, 4, 1, 0, 0, 0, 0, 0, 0));   // c25
    tbl.push_back(mk(1, 4, 4, 13, 1, 0, 0, 0, 0, 0, 0));  // c26
    // Freeze three cycles with the dependent sitting in EX
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));   // c27
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));   // c28
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));   // c29
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));   // c30 still held
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // c31
    // Flush coinciding with load-use
    tbl.push_back(mk(1, 3, 0, 9, 1, 1, 0, 0, 0, 0, 0));   // c32 lw x9
    tbl.push_back(mk(1, 9, 9, 10, 1, 0, 0, 1, 0, 0, 1));  // c33 flush + stall
    tbl.push_back(mk(1, 9, 9, 10, 1, 0, 0, 0, 0, 0, 0));  // c34 no second stall
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0));   // c35
    // Flush kills a plain ALU writer
    tbl.push_back(mk(1, 1, 2, 19, 1, 0, 0, 1, 0, 0, 0));  // c36
    tbl.push_back(mk(1, 19, 0, 20, 1, 0, 0, 0, 0, 0, 0)); // c37
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // c38 killed x19 not forwarded
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // c39
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // c40

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("reset", 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].vld, int'(tbl[i].rs1), int'(tbl[i].rs2), int'(tbl[i].rd),
            tbl[i].wren, tbl[i].load, tbl[i].stl, tbl[i].fls);
      #1;
      chk_out($sformatf("c%0d", i), int'(tbl[i].ea), int'(tbl[i].eb), int'(tbl[i].es));
    end

    // Asynchronous reset while a load-use stall is asserted
    @(negedge clk);
    drive(1, 3, 0, 9, 1, 1, 0, 0);
    @(negedge clk);
    drive(1, 9, 9, 10, 1, 0, 0, 0);
    #1;
    chk_out("rst_pre", 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("rst_after", 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_out("rst_next", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

- Forwarding and hazard controller for the 5-stage RV32I core.
- Tracks destination-register info for instructions in EX, MEM and WB in its own shadow pipeline registers.
- Drives the 2-bit select lines of the two EX-stage operand 3-to-1 muxes (register file / MEM-stage result / WB-stage result).
- Raises a one-cycle load-use stall when an instruction in ID needs a load result still in EX.

## Interface
Parameters:
- REG_ADDR_W, 5, architectural register index width
- SEL_W, 2, operand-mux select width

Ports:
- i_clk  input  1  core clock; all state updates on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_id_valid  input  1  ID holds a real instruction (0 = bubble)
- i_id_rs1, i_id_rs2  input  REG_ADDR_W  source indices of the ID instruction
- i_id_rd  input  REG_ADDR_W  destination index of the ID instruction
- i_id_rd_wren  input  1  ID instruction writes rd
- i_id_is_load  input  1  ID instruction is a load
- i_stall  input  1  global freeze (memory wait); holds every stage
- i_flush  input  1  branch/jump redirect; kills the ID instruction
- o_fwd_a_sel, o_fwd_b_sel  output  SEL_W  EX operand A/B select: 00 regfile, 01 MEM, 10 WB; 11 never driven
- o_load_use_stall  output  1  ID must hold and a bubble goes to EX this cycle

## Operation
- Shadow stages hold {valid, rs1, rs2, rd, wren, load}:
  - ex_q holds all fields.
  - mem_q holds {valid, rd, wren, load}.
  - wb_q holds {valid, rd, wren}.
- A stage is a writer when valid && wren && rd != 0. x0 never matches.
- Operand A select from ex_q.rs1, evaluated in priority order:
  - 01 if mem_q is a writer, !mem_q.load and mem_q.rd == ex_q.rs1.
  - 10 if wb_q is a writer and wb_q.rd == ex_q.rs1.
  - 00 otherwise, including when ex_q.valid = 0.
- Operand B: same rules using ex_q.rs2.
- A load in MEM is never a MEM-forward source; a matching load falls through to the WB check.
- o_load_use_stall = i_id_valid && ex_q.valid && ex_q.load && ex_q.wren && ex_q.rd != 0 && (ex_q.rd == i_id_rs1 || ex_q.rd == i_id_rs2). It ignores whether the ID instruction actually reads rs2; over-stall is accepted.
- Next-state priority on each rising edge:
  1. i_stall = 1: all stage registers hold. i_flush and the load-use condition have no effect that cycle, and the requester holds them.
  2. i_flush = 1: ex_q gets a bubble (valid = 0). mem_q ← ex_q, wb_q ← mem_q.
  3. o_load_use_stall = 1: ex_q gets a bubble, mem_q/wb_q advance, and ID is held by the pipeline.
  4. Otherwise: ex_q ← ID fields with valid = i_id_valid, mem_q ← ex_q, wb_q ← mem_q.
- A flush coinciding with a load-use stall is treated as a flush; the stall output may still be high that cycle and is harmless.
- The register file writes in WB with internal write-through, so no fourth forwarding source exists.

## Timing
- Reset (asynchronous assert, synchronous deassert by the core reset synchroniser) clears all valid bits.
- After reset, o_fwd_a_sel = o_fwd_b_sel = 00 and o_load_use_stall = 0.
- Reset asserted mid-operation discards all in-flight entries immediately.
- Select outputs are combinational from flops only. They are valid the same cycle the instruction sits in EX, with zero added latency.
- o_load_use_stall is combinational from ID inputs and ex_q.
- Load-use costs exactly one bubble. On the next cycle the load is in WB and the dependent instruction in EX gets select 10.
- Back-to-back writers to the same rd resolve to the youngest (MEM over WB).

## Structure
- fwd_pkg holds:
  - fwd_sel_e enum: FWD_REG = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10.
  - stage structs ex_stage_t, mem_stage_t, wb_stage_t.
  - REG_ADDR_W default constant.
- One sub-module fwd_match: given one source index plus the mem_q and wb_q stage structs, returns fwd_sel_e. Instantiated twice (A, B).
- Stage registers and stall logic stay in fwd_ctrl.

## Test plan
- ALU chain: add x5 then sub x6,x5,x7 back-to-back. When sub is in EX: a_sel = 01, b_sel = 00, no stall.
- Gap of one: add x5, nop, or x8,x1,x5. When or is in EX: a_sel = 00, b_sel = 10.
- Load-use: lw x9 then add x10,x9,x9. Stall is high one cycle, then one EX bubble (sels 00). Then add is in EX with a_sel = b_sel = 10.
- x0 and priority:
  - Writes to x0 (add x0…) followed by a read of x0: sels stay 00.
  - addi x4 then addi x4 again, then a use of x4: selects 01 (youngest).
- Freeze and flush:
  - i_stall held 3 cycles with a dependent in EX: sels are stable and stage registers unchanged.
  - i_flush with a load-use pending: ex_q becomes a bubble and no second stall occurs.
- Reset mid-stream: deassert i_rst_n asynchronously while a stall is high. Outputs go to 00/00/0 immediately with no clock edge.
